// File: rtl/rv32i_types.sv
// Shared fetch/decode types: WAY-lane fetch bundle and queue status encodings.
package rv32i_types;

   localparam int unsigned WAY          = 2;
   localparam int unsigned HISTORY_BITS = 10;

   // Queue status as seen by id_stage
   localparam logic [1:0] IQ_NORMAL = 2'b00;
   localparam logic [1:0] IQ_EMPTY  = 2'b01;
   localparam logic [1:0] IQ_FULL   = 2'b10;

   typedef struct packed {
      logic [WAY-1:0][31:0]           inst;
      logic [WAY-1:0][31:0]           pc;
      logic [WAY-1:0][31:0]           pc_next;
      logic [WAY-1:0]                 br_pred_valid;
      logic [WAY-1:0]                 br_pred_taken;
      logic [WAY-1:0][31:0]           br_pred_target;
      logic [WAY-1:0][HISTORY_BITS-1:0] br_pred_index;
   } iq_bundle_t;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of WAY-wide fetch bundles,
// head bundle presented combinationally to id_stage, emptied on flush.
module inst_queue
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic                                 enq,
   input  iq_bundle_t                           enq_data,
   output logic                                 enq_ready,
   input  logic                                 iq_pop,
   output logic                                 iq_resp,
   output logic [1:0]                           iq_status,
   output logic [WAY-1:0][31:0]                 iq_rdata,
   output logic [WAY-1:0][31:0]                 pc,
   output logic [WAY-1:0][31:0]                 pc_next,
   output logic [WAY-1:0]                       br_pred_valid,
   output logic [WAY-1:0]                       br_pred_taken,
   output logic [WAY-1:0][31:0]                 br_pred_target,
   output logic [WAY-1:0][HISTORY_BITS-1:0]     br_pred_index
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

   iq_bundle_t       mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic             full;
   logic             empty;
   logic             do_enq;
   logic             do_deq;
   iq_bundle_t       head_b;

   assign full   = (count == DEPTH_C);
   assign empty  = (count == '0);
   assign do_enq = enq && !full && !flush && !rst;
   assign do_deq = iq_pop && !empty && !flush && !rst;

   assign enq_ready = !full;
   assign iq_resp   = do_deq;

   // Bundle storage; written at tail on accepted enqueue, never reset
   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem[tail] <= enq_data;
      end
   end

   // Pointer and occupancy update; reset and flush both empty the queue
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_enq) tail <= tail + 1'b1;
         if (do_deq) head <= head + 1'b1;
         case ({do_enq, do_deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head bundle selection, zeroed while empty
   always_comb begin
      head_b = '0;
      if (!empty) begin
         head_b = mem[head];
      end
   end

   // Status derived from registered occupancy only
   always_comb begin
      iq_status = IQ_NORMAL;
      if (empty) begin
         iq_status = IQ_EMPTY;
      end else if (full) begin
         iq_status = IQ_FULL;
      end
   end

   assign iq_rdata       = head_b.inst;
   assign pc             = head_b.pc;
   assign pc_next        = head_b.pc_next;
   assign br_pred_valid  = head_b.br_pred_valid;
   assign br_pred_taken  = head_b.br_pred_taken;
   assign br_pred_target = head_b.br_pred_target;
   assign br_pred_index  = head_b.br_pred_index;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: driver pushes expected bundles on modelled
// acceptance, monitor compares head/resp/status on every falling edge.
module tb_inst_queue;
   import rv32i_types::*;

   localparam int DEPTH = 16;

   logic                             clk = 1'b0;
   logic                             rst, flush, enq, iq_pop;
   iq_bundle_t                       enq_data;
   logic                             enq_ready, iq_resp;
   logic [1:0]                       iq_status;
   logic [WAY-1:0][31:0]             iq_rdata, pc, pc_next, br_pred_target;
   logic [WAY-1:0]                   br_pred_valid, br_pred_taken;
   logic [WAY-1:0][HISTORY_BITS-1:0] br_pred_index;

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .enq(enq), .enq_data(enq_data),
      .enq_ready(enq_ready), .iq_pop(iq_pop), .iq_resp(iq_resp),
      .iq_status(iq_status), .iq_rdata(iq_rdata), .pc(pc), .pc_next(pc_next),
      .br_pred_valid(br_pred_valid), .br_pred_taken(br_pred_taken),
      .br_pred_target(br_pred_target), .br_pred_index(br_pred_index)
   );

   iq_bundle_t  exp_q[$];
   int          ref_count = 0;
   logic        exp_resp = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;
   int          resp_seen = 0;
   int          chk_seq = 0;
   int          chk_done = 0;
   int          chk_target = 0;
   logic [31:0] seed = 32'h2000_0000;
   int          base;

   function automatic iq_bundle_t mk(input logic [31:0] s);
      iq_bundle_t b;
      b.pc[0]             = s;
      b.pc[1]             = s + 32'd4;
      b.pc_next[0]        = s + 32'd4;
      b.pc_next[1]        = s + 32'd8;
      b.inst[0]           = s ^ 32'hA5A5_0013;
      b.inst[1]           = ~s;
      b.br_pred_valid     = s[1:0] ^ 2'b10;
      b.br_pred_taken     = s[3:2] ^ 2'b01;
      b.br_pred_target[0] = s + 32'h100;
      b.br_pred_target[1] = s - 32'h40;
      b.br_pred_index[0]  = s[15:6];
      b.br_pred_index[1]  = s[25:16];
      return b;
   endfunction

   iq_bundle_t act_b;
   always_comb begin
      act_b                = '0;
      act_b.inst           = iq_rdata;
      act_b.pc             = pc;
      act_b.pc_next        = pc_next;
      act_b.br_pred_valid  = br_pred_valid;
      act_b.br_pred_taken  = br_pred_taken;
      act_b.br_pred_target = br_pred_target;
      act_b.br_pred_index  = br_pred_index;
   end

   // Monitor: all comparisons happen here, away from the rising edge
   always @(negedge clk) begin
      iq_bundle_t e;
      logic [1:0] exp_st;
      if (!rst) begin
         exp_st = (ref_count == 0) ? IQ_EMPTY : (ref_count == DEPTH) ? IQ_FULL : IQ_NORMAL;
         n_vec++;
         if (iq_status !== exp_st) begin
            n_err++;
            $display("FAIL status t=%0t got %b want %b", $time, iq_status, exp_st);
         end
         n_vec++;
         if (enq_ready !== (ref_count != DEPTH)) begin
            n_err++;
            $display("FAIL enq_ready t=%0t got %b want %b", $time, enq_ready, ref_count != DEPTH);
         end
         n_vec++;
         if (iq_resp !== exp_resp) begin
            n_err++;
            $display("FAIL resp t=%0t got %b want %b", $time, iq_resp, exp_resp);
         end
         n_vec++;
         if (ref_count == 0 || exp_q.size() == 0) begin
            if (act_b !== iq_bundle_t'('0)) begin
               n_err++;
               $display("FAIL empty_head t=%0t got %h want 0", $time, act_b);
            end
         end else begin
            e = exp_q[0];
            if (act_b !== e) begin
               n_err++;
               $display("FAIL head t=%0t got pc0=%h (%h) want pc0=%h (%h)", $time, act_b.pc[0], act_b, e.pc[0], e);
            end
         end
         if (iq_resp === 1'b1) begin
            resp_seen++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      if (chk_seq != chk_done) begin
         chk_done = chk_seq;
         n_vec++;
         if (resp_seen != chk_target) begin
            n_err++;
            $display("FAIL resp_count t=%0t got %0d want %0d", $time, resp_seen, chk_target);
         end
      end
   end

   task automatic step(input logic e, input logic p, input logic f, input logic r);
      logic ae, ad;
      enq      = e;
      iq_pop   = p;
      flush    = f;
      rst      = r;
      enq_data = mk(seed);
      ae = e && (ref_count < DEPTH) && !f && !r;
      ad = p && (ref_count > 0) && !f && !r;
      exp_resp = ad;
      if (ae) exp_q.push_back(mk(seed));
      if (e) seed = seed + 32'h40;
      @(posedge clk);
      if (f || r) begin
         ref_count = 0;
         exp_q.delete();
      end else begin
         ref_count = ref_count + int'(ae) - int'(ad);
      end
      #1;
   endtask

   task automatic expect_resps(input int start, input int n);
      chk_target = start + n;
      chk_seq++;
      step(0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; enq = 1'b0; iq_pop = 1'b0; enq_data = '0;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // Single bundle through
      seed = 32'h1eceb000;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);

      // Fill, overflow attempt, drain in order
      for (int i = 0; i < 17; i++) step(1, 0, 0, 0);
      base = resp_seen;
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
      expect_resps(base, 16);

      // Wrap-around: enq 10, pop 8, enq 12, drain 14
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 8; i++)  step(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
      base = resp_seen;
      for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
      expect_resps(base, 14);

      // Simultaneous enq/pop at count 5
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      base = resp_seen;
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
      expect_resps(base, 5);

      // Simultaneous enq/pop at count 16: enq rejected
      for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      base = resp_seen;
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
      expect_resps(base, 15);

      // Simultaneous enq/pop at count 0: no bypass
      step(1, 1, 0, 0);
      base = resp_seen;
      for (int i = 0; i < 2; i++) step(0, 1, 0, 0);
      expect_resps(base, 1);

      // Flush at count 7 with enq and pop
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
      step(1, 1, 1, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      base = resp_seen;
      for (int i = 0; i < 2; i++) step(0, 1, 0, 0);
      expect_resps(base, 1);

      // Reset mid-operation at count 9
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
      step(1, 1, 0, 1);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
